// File: rtl/mx_int8_pkg.sv
// Shared constants and FSM state type for the MXINT8 block-sum datapath.
// Included by the block-sum top and its normalizer.
package mx_int8_pkg;

  localparam int SCALE_WIDTH = 8;
  localparam int ELEM_WIDTH  = 8;
  localparam int BLOCK_SIZE  = 32;
  localparam int ACC_WIDTH   = ELEM_WIDTH + $clog2(BLOCK_SIZE);

  localparam logic [SCALE_WIDTH-1:0] SCALE_NAN   = 8'hFF;
  localparam logic [SCALE_WIDTH-1:0] SCALE_MAX   = 8'hFE;
  localparam logic [ELEM_WIDTH-1:0]  ELEM_UNUSED = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    NORM,
    OUT
  } state_t;

endpackage

// File: rtl/mx_int8_sum_normalize.sv
// Combinational MXINT8 sum normalizer: shift search, round, overflow.
// MX_INT8_SUM_SATURATE_EN saturates scale overflow instead of NaN.
module mx_int8_sum_normalize #(
  parameter int AW   = mx_int8_pkg::ACC_WIDTH,
  parameter int SW   = mx_int8_pkg::SCALE_WIDTH,
  parameter int EW   = mx_int8_pkg::ELEM_WIDTH,
  parameter int KMAX = $clog2(mx_int8_pkg::BLOCK_SIZE)
) (
  input  logic signed [AW-1:0] acc,
  input  logic [SW-1:0]        scale,
  input  logic                 nan,
  output logic [SW-1:0]        out_scale,
  output logic [EW-1:0]        out_element,
  output logic                 out_nan
);
  import mx_int8_pkg::*;

  localparam logic [AW:0]   EMAX_W = (AW+1)'(2**(EW-1) - 1);
  localparam logic [EW-1:0] EMAX_E = EW'(2**(EW-1) - 1);

  logic          neg;
  logic [AW:0]   ext;
  logic [AW:0]   mag;
  logic [AW:0]   rnd;
  logic [AW:0]   t;
  logic          found;
  logic [SW:0]   k;
  logic [EW-1:0] m;
  logic [SW:0]   sum;

  always_comb begin
    neg   = acc[AW-1];
    ext   = {acc[AW-1], acc};
    mag   = neg ? -ext : ext;
    found = 1'b0;
    k     = '0;
    m     = '0;
    rnd   = '0;
    t     = '0;
    // smallest shift whose rounded magnitude fits in int8
    for (int i = 0; i <= KMAX; i++) begin
      rnd = ((AW+1)'(1) << i) >> 1;
      t   = (mag + rnd) >> i;
      if (!found && t <= EMAX_W) begin
        found = 1'b1;
        k     = (SW+1)'(i);
        m     = t[EW-1:0];
      end
    end
    sum = {1'b0, scale} + k;
  end

  always_comb begin
    out_scale   = sum[SW-1:0];
    out_element = neg ? -m : m;
    out_nan     = 1'b0;
    if (nan) begin
      out_scale   = SCALE_NAN;
      out_element = '0;
      out_nan     = 1'b1;
    end else if (sum > {1'b0, SCALE_MAX}) begin
`ifdef MX_INT8_SUM_SATURATE_EN
      out_scale   = SCALE_MAX;
      out_element = neg ? -EMAX_E : EMAX_E;
      out_nan     = 1'b0;
`else
      out_scale   = SCALE_NAN;
      out_element = '0;
      out_nan     = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/mx_int8_block_sum_seq.sv
// Multi-cycle MXINT8 block reducer: LANES-wide accumulate then normalize.
// MX_INT8_SUM_SATURATE_EN selects saturation on scale overflow.
module mx_int8_block_sum_seq #(
  parameter int BLOCK_SIZE  = mx_int8_pkg::BLOCK_SIZE,
  parameter int LANES       = 8,
  parameter int SCALE_WIDTH = mx_int8_pkg::SCALE_WIDTH,
  parameter int ELEM_WIDTH  = mx_int8_pkg::ELEM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SCALE_WIDTH-1:0] in_scale,
  input  logic [ELEM_WIDTH-1:0]  in_elements [BLOCK_SIZE],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SCALE_WIDTH-1:0] out_scale,
  output logic [ELEM_WIDTH-1:0]  out_element,
  output logic                   out_nan
);
  import mx_int8_pkg::*;

  localparam int AW    = ELEM_WIDTH + $clog2(BLOCK_SIZE);
  localparam int BEATS = BLOCK_SIZE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [ELEM_WIDTH-1:0]  elems_q [BLOCK_SIZE];
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   lane_sum;
  logic [BW-1:0]          beat_q;
  logic                   nan_q;
  logic                   lane_nan;
  logic [SCALE_WIDTH-1:0] oscale_q;
  logic [SCALE_WIDTH-1:0] n_scale;
  logic [ELEM_WIDTH-1:0]  oelem_q;
  logic [ELEM_WIDTH-1:0]  n_elem;
  logic                   onan_q;
  logic                   n_nan;
  logic                   fire;

  function automatic logic signed [AW-1:0] sext(
    input logic [ELEM_WIDTH-1:0] e
  );
    return {{(AW-ELEM_WIDTH){e[ELEM_WIDTH-1]}}, e};
  endfunction

  assign fire = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire) state_d = ACCUM;
      ACCUM:   if (beat_q == LAST) state_d = NORM;
      NORM:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = rst_n && (state_q == IDLE);
    out_valid   = (state_q == OUT);
    out_scale   = oscale_q;
    out_element = oelem_q;
    out_nan     = onan_q;
  end

  always_comb begin
    lane_sum = '0;
    lane_nan = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + sext(elems_q[int'(beat_q) * LANES + i]);
      lane_nan = lane_nan |
                 (elems_q[int'(beat_q) * LANES + i] == ELEM_UNUSED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q  <= '0;
      acc_q    <= '0;
      beat_q   <= '0;
      nan_q    <= 1'b0;
      oscale_q <= '0;
      oelem_q  <= '0;
      onan_q   <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) elems_q[i] <= '0;
    end else begin
      unique case (1'b1)
        fire: begin
          scale_q <= in_scale;
          elems_q <= in_elements;
          acc_q   <= '0;
          beat_q  <= '0;
          nan_q   <= (in_scale == SCALE_NAN);
        end
        (state_q == ACCUM): begin
          acc_q  <= acc_q + lane_sum;
          beat_q <= beat_q + 1'b1;
          nan_q  <= nan_q | lane_nan;
        end
        (state_q == NORM): begin
          oscale_q <= n_scale;
          oelem_q  <= n_elem;
          onan_q   <= n_nan;
        end
        default: ;
      endcase
    end
  end

  mx_int8_sum_normalize #(
    .AW   (AW),
    .SW   (SCALE_WIDTH),
    .EW   (ELEM_WIDTH),
    .KMAX ($clog2(BLOCK_SIZE))
  ) u_norm (
    .acc         (acc_q),
    .scale       (scale_q),
    .nan         (nan_q),
    .out_scale   (n_scale),
    .out_element (n_elem),
    .out_nan     (n_nan)
  );

endmodule

// File: tb/tb_mx_int8_block_sum_seq.sv
// Self-checking bench for mx_int8_block_sum_seq with an integer model.
// Honours MX_INT8_SUM_SATURATE_EN when computing expected overflow results.
module tb_mx_int8_block_sum_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_scale = '0;
  logic [7:0] in_elements [32];
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_scale;
  logic [7:0] out_element;
  logic       out_nan;

  int total = 0;
  int bad = 0;

  logic [7:0] elems [32];
  logic [7:0] scale_v;
  logic [7:0] exp_scale;
  logic [7:0] exp_elem;
  logic       exp_nan;

  always #5 clk = ~clk;

  mx_int8_block_sum_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_scale    (in_scale),
    .in_elements (in_elements),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_scale   (out_scale),
    .out_element (out_element),
    .out_nan     (out_nan)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model();
    int s = 0;
    int mag;
    int k;
    int m;
    int sc;
    bit n;
    n = (scale_v == 8'hFF);
    for (int i = 0; i < 32; i++) begin
      s += int'($signed(elems[i]));
      if (elems[i] == 8'h80) n = 1'b1;
    end
    mag = (s < 0) ? -s : s;
    k = 0;
    m = mag;
    while (m > 127) begin
      k++;
      m = (mag + (1 << (k - 1))) >> k;
    end
    sc = int'(scale_v) + k;
    if (n) begin
      exp_scale = 8'hFF; exp_elem = 8'h00; exp_nan = 1'b1;
    end else if (sc > 254) begin
`ifdef MX_INT8_SUM_SATURATE_EN
      exp_scale = 8'hFE;
      exp_elem  = (s < 0) ? 8'h81 : 8'h7F;
      exp_nan   = 1'b0;
`else
      exp_scale = 8'hFF; exp_elem = 8'h00; exp_nan = 1'b1;
`endif
    end else begin
      exp_scale = 8'(sc);
      exp_elem  = 8'((s < 0) ? -m : m);
      exp_nan   = 1'b0;
    end
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) elems[i] = v;
  endtask

  task automatic run_block(input string tag, input int stall,
                           input bit hold);
    int n;
    model();
    in_scale    = scale_v;
    in_elements = elems;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    tick();
    if (!hold) in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd6);
    chk({tag, "_scale"}, 32'(out_scale), 32'(exp_scale));
    chk({tag, "_elem"}, 32'(out_element), 32'(exp_elem));
    chk({tag, "_nan"}, 32'(out_nan), 32'(exp_nan));
    for (int c = 0; c < stall; c++) begin
      tick();
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_scale"}, 32'(out_scale), 32'(exp_scale));
      chk({tag, "_stall_elem"}, 32'(out_element), 32'(exp_elem));
      chk({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 32; i++) in_elements[i] = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_scale", 32'(out_scale), 32'd0);
    chk("rst_out_elem", 32'(out_element), 32'd0);
    chk("rst_out_nan", 32'(out_nan), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    fill(8'd1); scale_v = 8'd127;
    run_block("d1_ones", 0, 0);
    chk("d1_const_elem", 32'(out_element), 32'd32);

    fill(8'd127); scale_v = 8'd10;
    run_block("d2_max", 0, 0);
    chk("d2_const_scale", 32'(out_scale), 32'd15);
    scale_v = 8'd250;
    run_block("d2_ovf", 0, 0);

    fill(8'd0); elems[0] = 8'd127; elems[1] = 8'd127; elems[2] = 8'd1;
    scale_v = 8'd20;
    run_block("d3_round", 0, 0);
    chk("d3_const_elem", 32'(out_element), 32'd64);

    for (int i = 0; i < 32; i++) elems[i] = (i < 16) ? 8'd100 : 8'h9C;
    scale_v = 8'd50;
    run_block("d4_cancel", 0, 0);
    fill(8'd0); scale_v = 8'd0;
    run_block("d4_zero", 0, 0);

    fill(8'd1); elems[31] = 8'h80; scale_v = 8'd5;
    run_block("d5_unused", 0, 0);
    fill(8'd2); scale_v = 8'hFF;
    run_block("d5_scale_nan", 0, 0);

    fill(8'hFF); scale_v = 8'd3;
    run_block("d6_stall", 5, 1);
    chk("d6_ready_after", 32'(in_ready), 32'd1);
    fill(8'h80); elems[0] = 8'd5; fill(8'd3); scale_v = 8'd9;
    run_block("d6_next", 0, 0);

    fill(8'd7); scale_v = 8'd40;
    in_scale = scale_v; in_elements = elems; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_scale", 32'(out_scale), 32'd0);
    chk("mid_rst_elem", 32'(out_element), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_emit", 32'(seen), 32'd0);
    chk("mid_rst_ready_back", 32'(in_ready), 32'd1);

    for (int r = 0; r < 24; r++) begin
      scale_v = 8'($urandom_range(0, 254));
      for (int i = 0; i < 32; i++) begin
        case (r % 3)
          0:       elems[i] = 8'($urandom_range(0, 255));
          1:       elems[i] = 8'(int'($urandom_range(0, 8)) - 4);
          default: elems[i] = 8'($urandom_range(0, 127));
        endcase
      end
      run_block("rand", (r % 4 == 0) ? 2 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
